// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its
// surroundings: PLL lock input, relock request, resets and status.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state_o;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail,
    output state_o,
    output retry_cnt,
    output loss_cnt
  );

  modport slave (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail,
    input  state_o,
    input  retry_cnt,
    input  loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: resets the PLL, waits for and qualifies lock,
// then releases the system reset; retries on timeout, re-sequences on loss.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input logic refclk,
  input logic rst,
  pll_lock_supervisor_if.master sup
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0] RETRY_MAX =
    8'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic [1:0]       sync_q, sync_d;
  logic             locked_s;
  logic             restart;

  // pll_locked is asynchronous to refclk
  assign sync_d   = {sync_q[0], sup.pll_locked};
  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    restart = 1'b0;
    cnt_d   = cnt_q + 1'b1;
    if (sup.relock_req) begin
      state_d = S_PLL_RESET;
      retry_d = 8'd0;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == RST_LAST)
            state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 8'd1;
              state_d = S_PLL_RESET;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s)
            state_d = S_WAIT_LOCK;
          else if (cnt_q == STB_LAST)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            if (loss_q != 8'hff)
              loss_d = loss_q + 8'd1;
            retry_d = 8'd0;
            state_d = S_PLL_RESET;
          end
        end
        S_FAIL: begin
        end
        default: state_d = S_PLL_RESET;
      endcase
    end
    if (restart || (state_d != state_q))
      cnt_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_PLL_RESET;
      cnt_q   <= '0;
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      sync_q  <= sync_d;
    end
  end

  assign sup.pll_rst   = (state_q == S_PLL_RESET) ||
                         (state_q == S_FAIL);
  assign sup.sys_rst   = (state_q != S_RUN);
  assign sup.ready     = (state_q == S_RUN);
  assign sup.fail      = (state_q == S_FAIL);
  assign sup.state_o   = state_q;
  assign sup.retry_cnt = retry_q;
  assign sup.loss_cnt  = loss_q;

endmodule
